ped_walk_ctrl: RTL and testbench
================================

PED_WALK_CTRL -- requirements
Module: ped_walk_ctrl

Interface
REQ-001 Parameter WALK_CYCLES, default 6: steady-walk duration in clock cycles (range 1..15).
REQ-002 Parameter FLASH_CYCLES, default 3: flashing-walk duration in clock cycles (range 1..15; WALK_CYCLES+FLASH_CYCLES <= 15).
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 light  input  3  vehicle-light code from the upstream traffic-light stage (RED=3'b101, GREEN=3'b110, BLUE=3'b011).
REQ-006 ped_btn  input  1  raw pedestrian push-button, asynchronous to clock, active-high.
REQ-007 req_pending  output  1  a pedestrian request is latched and not yet served.
REQ-008 walk  output  1  steady walk lamp.
REQ-009 walk_flash  output  1  flashing-walk phase indicator.
REQ-010 dont_walk  output  1  don't-walk lamp; high whenever walk and walk_flash are both low.
REQ-011 countdown  output  4  cycles remaining in the combined walk+flash phase; 0 otherwise.
REQ-012 fault  output  1  illegal light code seen; sticky until reset.

Function
REQ-013 ped_btn SHALL pass through a 2-flop synchronizer; a request event is a 0->1 edge of the second flop's output.
REQ-014 Latency: ped_btn rising before edge N SHALL set req_pending at edge N+3 (two sync edges plus the latch edge).
REQ-015 FSM states SHALL be IDLE, PENDING, WALK, FLASH, FAULT.
REQ-016 IDLE: request event -> PENDING, req_pending=1.
REQ-017 red_entry SHALL mean light==RED this cycle and the registered previous light != RED.
REQ-018 PENDING: red_entry -> WALK; req_pending clears on the same edge; countdown loads WALK_CYCLES+FLASH_CYCLES.
REQ-019 A request arriving mid-red SHALL wait for the next red_entry; no walk starts partway through a red.
REQ-020 WALK: walk=1; countdown decrements by 1 each cycle; after WALK_CYCLES cycles in WALK -> FLASH.
REQ-021 FLASH: walk_flash=1, walk=0; countdown continues decrementing; after FLASH_CYCLES cycles -> IDLE with countdown=0.
REQ-022 In WALK or FLASH, if light leaves RED, the FSM SHALL go to IDLE on that edge, with countdown=0 and dont_walk=1 in the next cycle (safety abort).
REQ-023 Request events during WALK or FLASH SHALL set req_pending and exit to PENDING instead of IDLE; duplicate events while pending are ignored.
REQ-024 A request event on the same edge as red_entry in IDLE SHALL go to PENDING only; it is served at the next red_entry.
REQ-025 Any light code other than RED, GREEN or BLUE SHALL force FAULT on the next edge from any state: walk=0, walk_flash=0, dont_walk=1, countdown=0, req_pending=0, fault=1.
REQ-026 FAULT SHALL be exited only by reset.
REQ-027 countdown SHALL never wrap below 0; its arithmetic is 4-bit unsigned.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On reset: state=IDLE, synchronizer flops=0, previous-light register=RED (no false red_entry), req_pending=0, walk=0, walk_flash=0, dont_walk=1, countdown=0, fault=0.
REQ-030 Reset asserted mid-WALK or mid-FLASH SHALL abort the phase on that edge and discard any pending request.

Structure
REQ-031 Light codes RED/GREEN/BLUE and the FSM state encoding SHALL live in a shared traffic package used by both the traffic-light stage and this block.
REQ-032 The synchronizer plus edge detector SHALL be a sub-module named btn_sync_edge.

Verification
REQ-033 Press ped_btn during GREEN; light goes GREEN->RED -> walk=1 for 6 cycles with countdown 9..4, then walk_flash=1 for 3 cycles with countdown 3..1, then dont_walk=1 and countdown=0.
REQ-034 Press ped_btn at the 4th cycle of RED -> no walk in that red; walk starts at the next red_entry.
REQ-035 In WALK at countdown=7, force light=GREEN -> next cycle walk=0, dont_walk=1, countdown=0, state IDLE.
REQ-036 Drive light=3'b000 for one cycle during PENDING -> fault=1, req_pending=0, dont_walk=1; stays so until reset, then all outputs return to reset values.
REQ-037 Pulse ped_btn 1 cycle, then assert reset at cycle 2 -> req_pending stays 0 after reset; press during FLASH -> req_pending=1, FSM ends in PENDING.

Source files
------------

// File: rtl/ped_walk_ctrl_pkg.sv
// Traffic definitions shared by the traffic-light stage and the pedestrian walk controller:
// vehicle-light codes, pedestrian FSM encoding and a light-code legality helper.
package ped_walk_ctrl_pkg;

    localparam logic [2:0] LIGHT_RED   = 3'b101;
    localparam logic [2:0] LIGHT_GREEN = 3'b110;
    localparam logic [2:0] LIGHT_BLUE  = 3'b011;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        WALK    = 3'd2,
        FLASH   = 3'd3,
        FAULT   = 3'd4
    } ped_state_t;

    function automatic logic is_legal_light(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_GREEN) || (code == LIGHT_BLUE);
    endfunction

endpackage

// File: rtl/ped_walk_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for the raw push-button followed by a registered rising-edge
// detector on the synchronized level; rise is a one-cycle pulse.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic sync_meta;
    logic sync_out;
    logic sync_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            sync_prev <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_out  <= sync_meta;
            sync_prev <= sync_out;
            rise      <= sync_out & ~sync_prev;
        end
    end

endmodule

// File: rtl/ped_walk_ctrl.sv
// Pedestrian walk controller: latches button requests and runs a walk/flash phase that
// starts only on entry into vehicle RED, aborting safely if RED ends early.
module ped_walk_ctrl
    import ped_walk_ctrl_pkg::*;
#(
    parameter int WALK_CYCLES  = 6,
    parameter int FLASH_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] light,
    input  logic       ped_btn,
    output logic       req_pending,
    output logic       walk,
    output logic       walk_flash,
    output logic       dont_walk,
    output logic [3:0] countdown,
    output logic       fault
);

    localparam logic [3:0] TOTAL_LOAD = 4'(WALK_CYCLES + FLASH_CYCLES);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_CYCLES);

    ped_state_t state;
    ped_state_t next_state;
    logic [2:0] prev_light;
    logic       btn_event;
    logic       light_is_red;
    logic       red_entry;
    logic       next_req;
    logic [3:0] next_count;

    btn_sync_edge u_btn_sync_edge (
        .clock (clock),
        .reset (reset),
        .btn   (ped_btn),
        .rise  (btn_event)
    );

    assign light_is_red = (light == LIGHT_RED);
    assign red_entry    = light_is_red && (prev_light != LIGHT_RED);

    always_comb begin
        next_state = state;
        next_req   = req_pending;
        next_count = countdown;
        case (state)
            IDLE: begin
                // A request coinciding with red_entry is only latched; it waits for the next red.
                if (btn_event) begin
                    next_state = PENDING;
                    next_req   = 1'b1;
                end
            end
            PENDING: begin
                if (red_entry) begin
                    next_state = WALK;
                    next_req   = 1'b0;
                    next_count = TOTAL_LOAD;
                end
            end
            WALK, FLASH: begin
                if (btn_event) begin
                    next_req = 1'b1;
                end
                if (!light_is_red) begin
                    next_state = next_req ? PENDING : IDLE;
                    next_count = 4'd0;
                end else begin
                    next_count = (countdown != 4'd0) ? countdown - 4'd1 : 4'd0;
                    if (state == WALK && next_count == FLASH_LOAD) begin
                        next_state = FLASH;
                    end else if (state == FLASH && next_count == 4'd0) begin
                        next_state = next_req ? PENDING : IDLE;
                    end
                end
            end
            FAULT: begin
                next_req   = 1'b0;
                next_count = 4'd0;
            end
            default: begin
                next_state = FAULT;
                next_req   = 1'b0;
                next_count = 4'd0;
            end
        endcase

        // An unknown light code overrides everything, whatever the current state.
        if (!is_legal_light(light)) begin
            next_state = FAULT;
            next_req   = 1'b0;
            next_count = 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            prev_light  <= LIGHT_RED;
            req_pending <= 1'b0;
            walk        <= 1'b0;
            walk_flash  <= 1'b0;
            dont_walk   <= 1'b1;
            countdown   <= 4'd0;
            fault       <= 1'b0;
        end else begin
            state       <= next_state;
            prev_light  <= light;
            req_pending <= next_req;
            walk        <= (next_state == WALK);
            walk_flash  <= (next_state == FLASH);
            dont_walk   <= !((next_state == WALK) || (next_state == FLASH));
            countdown   <= next_count;
            fault       <= (next_state == FAULT);
        end
    end

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Directed bench for ped_walk_ctrl: hand-timed light/button sequences with expected lamp,
// request and countdown values checked by immediate assertions after each step.
module tb_ped_walk_ctrl;
    import ped_walk_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] light;
    logic       ped_btn;
    logic       req_pending;
    logic       walk;
    logic       walk_flash;
    logic       dont_walk;
    logic [3:0] countdown;
    logic       fault;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ped_walk_ctrl #(
        .WALK_CYCLES  (6),
        .FLASH_CYCLES (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .light       (light),
        .ped_btn     (ped_btn),
        .req_pending (req_pending),
        .walk        (walk),
        .walk_flash  (walk_flash),
        .dont_walk   (dont_walk),
        .countdown   (countdown),
        .fault       (fault)
    );

    // Inputs are set just after an edge and held through the next one; outputs are read 1 ns later.
    task automatic apply_stimulus(input logic [2:0] l, input logic b);
        light   = l;
        ped_btn = b;
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic r, input logic w, input logic f,
                                input logic dw, input logic flt, input logic [3:0] cd);
        logic [8:0] observed;
        logic [8:0] expected;
        observed = {req_pending, walk, walk_flash, dont_walk, fault, countdown};
        expected = {r, w, f, dw, flt, cd};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed{req,walk,flash,dont,fault,cd}=%b expected=%b",
                   tag, observed, expected);
        end
    endtask

    initial begin
        reset   = 1'b1;
        light   = LIGHT_GREEN;
        ped_btn = 1'b0;
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("reset_values", 0, 0, 0, 1, 0, 4'd0);
        reset = 1'b0;

        // Press during green, full walk and flash on the next red.
        apply_stimulus(LIGHT_GREEN, 1'b1);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("latency_not_yet", 0, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("latency_pending", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("walk_cd9", 0, 1, 0, 0, 0, 4'd9);
        for (int i = 8; i >= 4; i--) begin
            apply_stimulus(LIGHT_RED, 1'b0);
            check_output($sformatf("walk_cd%0d", i), 0, 1, 0, 0, 0, 4'(i));
        end
        for (int i = 3; i >= 1; i--) begin
            apply_stimulus(LIGHT_RED, 1'b0);
            check_output($sformatf("flash_cd%0d", i), 0, 0, 1, 0, 0, 4'(i));
        end
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("phase_done_idle", 0, 0, 0, 1, 0, 4'd0);

        // Press in the 4th red cycle: no walk until the following red.
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b1);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("midred_pending", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("midred_no_walk", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("midred_green_wait", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("next_red_walk", 0, 1, 0, 0, 0, 4'd9);

        // Light leaves red mid-walk at countdown 7.
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("abort_walk_cd7", 0, 1, 0, 0, 0, 4'd7);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("abort_idle", 0, 0, 0, 1, 0, 4'd0);

        // Request event on the same edge as red_entry only latches.
        apply_stimulus(LIGHT_GREEN, 1'b1);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("same_edge_pending", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("same_edge_still_pending", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("same_edge_served", 0, 1, 0, 0, 0, 4'd9);

        // Press at countdown 6 lands in flash; phase exits to PENDING.
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b1);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("flash_before_req", 0, 0, 1, 0, 0, 4'd3);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("flash_req_latched", 1, 0, 1, 0, 0, 4'd2);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("flash_req_cd1", 1, 0, 1, 0, 0, 4'd1);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("flash_exit_pending", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("flash_req_served", 0, 1, 0, 0, 0, 4'd9);

        // Button pulse then reset mid-walk: phase aborted, request discarded.
        apply_stimulus(LIGHT_RED, 1'b1);
        reset = 1'b1;
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("reset_midwalk", 0, 0, 0, 1, 0, 4'd0);
        reset = 1'b0;
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("no_req_after_reset", 0, 0, 0, 1, 0, 4'd0);

        apply_stimulus(LIGHT_BLUE, 1'b0);
        check_output("blue_is_legal", 0, 0, 0, 1, 0, 4'd0);

        // Illegal light code while pending: sticky fault until reset.
        apply_stimulus(LIGHT_GREEN, 1'b1);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("pre_fault_pending", 1, 0, 0, 1, 0, 4'd0);
        apply_stimulus(3'b000, 1'b0);
        check_output("fault_entered", 0, 0, 0, 1, 1, 4'd0);
        apply_stimulus(LIGHT_GREEN, 1'b0);
        apply_stimulus(LIGHT_RED, 1'b0);
        check_output("fault_sticky", 0, 0, 0, 1, 1, 4'd0);
        reset = 1'b1;
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("fault_reset", 0, 0, 0, 1, 0, 4'd0);
        reset = 1'b0;
        apply_stimulus(LIGHT_GREEN, 1'b0);
        check_output("post_fault_idle", 0, 0, 0, 1, 0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
